layer_xfer_ctrl: RTL and testbench

LAYER_XFER_CTRL -- requirements
Module: layer_xfer_ctrl

---
 rtl/layer_xfer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_layer_xfer_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_xfer_ctrl.sv
// Layer transfer controller: walks a dim_x * dim_y * num_ch tensor in x-fastest order,
// issuing source reads and echoing them RD_LAT cycles later as sequential destination writes.
module layer_xfer_ctrl #(
   parameter int RD_LAT = 1,
   parameter int IDX_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             hold,
   input  logic [IDX_W-1:0] cfg_dim_x,
   input  logic [IDX_W-1:0] cfg_dim_y,
   input  logic [IDX_W-1:0] cfg_num_ch,
   output logic             busy,
   output logic             done,
   output logic             src_rd_en,
   output logic [IDX_W-1:0] src_x,
   output logic [IDX_W-1:0] src_y,
   output logic [IDX_W-1:0] src_ch,
   output logic             dst_wr_en,
   output logic [IDX_W-1:0] dst_addr
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  dim_x_q, dim_x_d;
   logic [IDX_W-1:0]  dim_y_q, dim_y_d;
   logic [IDX_W-1:0]  num_ch_q, num_ch_d;
   logic [IDX_W-1:0]  x_q, x_d;
   logic [IDX_W-1:0]  y_q, y_d;
   logic [IDX_W-1:0]  ch_q, ch_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic [RD_LAT-1:0] valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic rd_en;
   logic last_x, last_y, last_ch;
   logic cfg_ok;

   always_comb begin
      // NOTE: every _d starts from its _q so no branch of the case below can infer a latch.
      state_d  = state_q;
      dim_x_d  = dim_x_q;
      dim_y_d  = dim_y_q;
      num_ch_d = num_ch_q;
      x_d      = x_q;
      y_d      = y_q;
      ch_d     = ch_q;
      addr_d   = addr_q;

      rd_en   = (state_q == ISSUE) && !hold;
      last_x  = (x_q  == dim_x_q  - IDX_W'(1));
      last_y  = (y_q  == dim_y_q  - IDX_W'(1));
      last_ch = (ch_q == num_ch_q - IDX_W'(1));
      cfg_ok  = (cfg_dim_x != '0) && (cfg_dim_y != '0) && (cfg_num_ch != '0);

      // Read-valid pipeline runs free of hold so every issued read lands exactly RD_LAT later.
      valid_d = (valid_q << 1) | RD_LAT'(rd_en);
      if (valid_q[RD_LAT-1]) begin
         addr_d = addr_q + IDX_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  dim_x_d  = cfg_dim_x;
                  dim_y_d  = cfg_dim_y;
                  num_ch_d = cfg_num_ch;
                  x_d      = '0;
                  y_d      = '0;
                  ch_d     = '0;
                  addr_d   = '0;
                  state_d  = ISSUE;
               end else begin
                  state_d  = DONE;
               end
            end
         end
         ISSUE: begin
            if (rd_en) begin
               if (!last_x) begin
                  x_d = x_q + IDX_W'(1);
               end else begin
                  x_d = '0;
                  if (!last_y) begin
                     y_d = y_q + IDX_W'(1);
                  end else begin
                     y_d = '0;
                     if (!last_ch) begin
                        ch_d = ch_q + IDX_W'(1);
                     end else begin
                        ch_d    = '0;
                        state_d = DRAIN;
                     end
                  end
               end
            end
         end
         DRAIN: begin
            // Leave once the write now on dst_wr_en is the last one in flight.
            if (valid_d == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            addr_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ISSUE) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         dim_x_q  <= '0;
         dim_y_q  <= '0;
         num_ch_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         ch_q     <= '0;
         addr_q   <= '0;
         valid_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of order.
         state_q  <= state_d;
         dim_x_q  <= dim_x_d;
         dim_y_q  <= dim_y_d;
         num_ch_q <= num_ch_d;
         x_q      <= x_d;
         y_q      <= y_d;
         ch_q     <= ch_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign src_rd_en = rd_en;
   assign src_x     = x_q;
   assign src_y     = y_q;
   assign src_ch    = ch_q;
   assign dst_wr_en = valid_q[RD_LAT-1];
   assign dst_addr  = addr_q;

endmodule

// File: tb/tb_layer_xfer_ctrl.sv
// Scoreboard bench for layer_xfer_ctrl: expected reads/writes are queued per transfer,
// a negedge monitor pops and compares, and the driver checks busy/done timing per cycle.
module tb_layer_xfer_ctrl;
   localparam int RD_LAT = 3;
   localparam int IDX_W  = 16;

   localparam int HOLD_NONE  = 0;
   localparam int HOLD_FIXED = 1;
   localparam int HOLD_RAND  = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             hold;
   logic [IDX_W-1:0] cfg_dim_x;
   logic [IDX_W-1:0] cfg_dim_y;
   logic [IDX_W-1:0] cfg_num_ch;
   logic             busy;
   logic             done;
   logic             src_rd_en;
   logic [IDX_W-1:0] src_x;
   logic [IDX_W-1:0] src_y;
   logic [IDX_W-1:0] src_ch;
   logic             dst_wr_en;
   logic [IDX_W-1:0] dst_addr;

   layer_xfer_ctrl #(.RD_LAT(RD_LAT), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .hold       (hold),
      .cfg_dim_x  (cfg_dim_x),
      .cfg_dim_y  (cfg_dim_y),
      .cfg_num_ch (cfg_num_ch),
      .busy       (busy),
      .done       (done),
      .src_rd_en  (src_rd_en),
      .src_x      (src_x),
      .src_y      (src_y),
      .src_ch     (src_ch),
      .dst_wr_en  (dst_wr_en),
      .dst_addr   (dst_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int ch;
   } rd_t;

   rd_t exp_rd[$];
   int  exp_wr[$];

   int n_chk = 0;
   int n_err = 0;
   bit mon_en = 1'b0;
   logic [RD_LAT-1:0] rd_hist = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: a read is echoed as a write RD_LAT cycles later unless a reset edge intervenes.
   always @(negedge clk) begin
      if (mon_en) begin
         rd_t e;
         int  a;
         check("wr_latency", dst_wr_en, rd_hist[RD_LAT-1]);
         if (src_rd_en) begin
            if (exp_rd.size() == 0) begin
               check("rd_unexpected", src_rd_en, 0);
            end else begin
               e = exp_rd.pop_front();
               check("rd_x",  src_x,  e.x);
               check("rd_y",  src_y,  e.y);
               check("rd_ch", src_ch, e.ch);
            end
         end
         if (dst_wr_en) begin
            if (exp_wr.size() == 0) begin
               check("wr_unexpected", dst_wr_en, 0);
            end else begin
               a = exp_wr.pop_front();
               check("wr_addr", dst_addr, a);
            end
         end
         if (!busy && !done) begin
            check("idle_strobes", {src_rd_en, dst_wr_en}, 0);
            check("idle_idx", {src_x, src_y, src_ch}, 0);
            check("idle_addr", dst_addr, 0);
         end
         rd_hist = (rd_hist << 1) | RD_LAT'(src_rd_en);
         if (!reset) rd_hist = '0;
      end
   end

   task automatic push_expect(input int dx, input int dy, input int nc, input int limit);
      int n = 0;
      for (int c = 0; c < nc; c++)
         for (int y = 0; y < dy; y++)
            for (int x = 0; x < dx; x++) begin
               if (n < limit) exp_rd.push_back('{x: x, y: y, ch: c});
               n++;
            end
   endtask

   task automatic run_xfer(input int dx, input int dy, input int nc,
                           input int hold_mode, input int hold_pct, input bit second_start);
      int  n      = dx * dy * nc;
      bit  zero   = (n == 0);
      int  issued = 0;
      int  last   = 0;
      int  k      = 0;
      push_expect(dx, dy, nc, n);
      for (int a = 0; a < n; a++) exp_wr.push_back(a % (1 << IDX_W));

      @(posedge clk); #1;
      start      = 1'b1;
      hold       = 1'b0;
      cfg_dim_x  = IDX_W'(dx);
      cfg_dim_y  = IDX_W'(dy);
      cfg_num_ch = IDX_W'(nc);
      forever begin
         @(posedge clk); #1;
         k++;
         start      = second_start && (k == 2);
         cfg_dim_x  = IDX_W'($urandom_range(0, 7));
         cfg_dim_y  = IDX_W'($urandom_range(0, 7));
         cfg_num_ch = IDX_W'($urandom_range(0, 7));
         if (issued < n) begin
            case (hold_mode)
               HOLD_FIXED: hold = (k == 2) || (k == 3);
               HOLD_RAND:  hold = ($urandom_range(0, 99) < hold_pct) && (k < 3 * n + 10);
               default:    hold = 1'b0;
            endcase
         end else begin
            hold = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (zero) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_strobes", {src_rd_en, dst_wr_en}, 0);
            break;
         end else if (issued < n) begin
            check("issue_busy", {busy, done}, 2'b10);
            check("issue_rd_en", src_rd_en, !hold);
            if (!hold) begin
               issued++;
               if (issued == n) last = k;
            end
         end else if (k <= last + RD_LAT) begin
            check("drain_busy", {busy, done}, 2'b10);
            check("drain_rd_en", src_rd_en, 0);
         end else begin
            check("done_pulse", {busy, done}, 2'b01);
            break;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      hold  = 1'b0;
      @(negedge clk);
      check("after_done", {busy, done}, 0);
      check("rd_queue_left", exp_rd.size(), 0);
      check("wr_queue_left", exp_wr.size(), 0);
   endtask

   // Reset in cycle 6 of a 4x4x2 transfer: 6 reads observed, only the first 3 writes land.
   task automatic run_abort();
      push_expect(4, 4, 2, 6);
      for (int a = 0; a < 6 - RD_LAT; a++) exp_wr.push_back(a);
      @(posedge clk); #1;
      start      = 1'b1;
      cfg_dim_x  = 4;
      cfg_dim_y  = 4;
      cfg_num_ch = 2;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         start = (k == 6);
         if (k == 6) reset = 1'b0;
         @(negedge clk);
         check("abort_busy", busy, 1);
         check("abort_rd_en", src_rd_en, 1);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("abort_flags", {busy, done, src_rd_en, dst_wr_en}, 0);
      check("abort_idx", {src_x, src_y, src_ch}, 0);
      check("abort_addr", dst_addr, 0);
      for (int k = 0; k < RD_LAT + 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("abort_no_done", {busy, done}, 0);
      end
      check("abort_rd_left", exp_rd.size(), 0);
      check("abort_wr_left", exp_wr.size(), 0);
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      hold       = 1'b0;
      cfg_dim_x  = '0;
      cfg_dim_y  = '0;
      cfg_num_ch = '0;
      repeat (3) @(posedge clk);
      #1;
      start      = 1'b1;
      cfg_dim_x  = 2;
      cfg_dim_y  = 2;
      cfg_num_ch = 1;
      @(posedge clk); #1;
      reset  = 1'b1;
      start  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_flags", {busy, done, src_rd_en, dst_wr_en}, 0);
      check("rst_idx", {src_x, src_y, src_ch}, 0);
      check("rst_addr", dst_addr, 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_beats_start", {busy, done}, 0);

      run_xfer(2, 2, 1, HOLD_NONE, 0, 1'b0);
      run_xfer(2, 2, 1, HOLD_FIXED, 0, 1'b0);
      run_xfer(2, 0, 1, HOLD_NONE, 0, 1'b0);
      run_xfer(0, 3, 3, HOLD_NONE, 0, 1'b1);
      run_xfer(1, 1, 1, HOLD_RAND, 50, 1'b1);
      run_xfer(5, 1, 1, HOLD_RAND, 30, 1'b0);
      run_xfer(1, 5, 2, HOLD_RAND, 30, 1'b0);

      for (int t = 0; t < 12; t++) begin
         int dx = $urandom_range(1, 5);
         int dy = $urandom_range(1, 5);
         int nc = $urandom_range(1, 4);
         if ($urandom_range(0, 7) == 0) dx = 0;
         run_xfer(dx, dy, nc, HOLD_RAND, $urandom_range(0, 50), 1'($urandom_range(0, 1)));
      end

      run_abort();
      run_xfer(1, 1, 1, HOLD_NONE, 0, 1'b0);
      run_xfer(26, 26, 16, HOLD_RAND, 10, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
